sram_buffer_3port: RTL and testbench
====================================

Name: sram_buffer_3port

Overview:
- Three-port shared SRAM buffer that responds to the memory controller's port1/port2/port3 en/we/addr/din/dout interface.
- Behavioural word array with a fixed 2-cycle read pipeline per port, deterministic write-collision resolution, out-of-range detection, and access statistics.
- Sits between the memory controller and physical storage. It is the responder end of the controller's SRAM port protocol.

Parameters:
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 22, port address width, matching the controller
- DEPTH, 4096, implemented words; valid addresses are 0..DEPTH-1

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- portK_en  in  1  access strobe for port K (K = 1, 2, 3; one set of signals per port)
- portK_we  in  1  1 = write, 0 = read
- portK_addr  in  ADDR_WIDTH  word address
- portK_din  in  DATA_WIDTH  write data
- portK_dout  out  DATA_WIDTH  read data, registered and held
- portK_rvalid  out  1  one-cycle pulse when portK_dout carries a new read result
- stat_clr  in  1  synchronous clear of all counters
- err_clr  in  1  synchronous clear of the sticky error flags
- rd_count  out  16  completed in-range reads across all ports, saturates at 0xFFFF
- wr_count  out  16  committed writes across all ports, saturates at 0xFFFF
- collision_count  out  8  same-cycle, same-address write collisions, saturates at 0xFF
- oor_err  out  1  sticky: an access had addr >= DEPTH
- parity_err  out  1  sticky parity error (tied to 0 when SRAM_PARITY_EN is not defined)

Behaviour:
- Reset:
  - All portK_dout are 0, all portK_rvalid are 0.
  - All counters are 0; oor_err and parity_err are 0.
  - Read pipeline valid bits are cleared.
  - Array contents are not reset.
  - Reset asserted mid-operation discards in-flight reads: no rvalid pulse follows.
- Timing: a request is sampled at rising edge E0, at the end of the cycle in which en=1.
- Write: when en=1 and we=1, mem[addr] <= din at E0. The data is visible to any read sampled at E1 or later.
- Read pipeline:
  - Stage 1 captures mem[addr] at E0.
  - Stage 2 loads portK_dout at E1, with portK_rvalid=1 for exactly that one cycle.
  - Net effect: data is valid in the second cycle after the en cycle. This matches the controller's GRANT → WAIT → RETURN sequence.
- Back-to-back reads: one per cycle per port is fully pipelined.
- dout holding: portK_dout holds its last read value until the next read completes. Writes never change dout.
- Read-during-write, same address, same edge (any ports): the read returns the OLD data (read-first).
- Write collision (two or more ports write the same address at the same edge):
  - The lowest-numbered port wins; the other writes are dropped.
  - collision_count increments by 1 per edge, regardless of how many ports collided.
  - wr_count increments by the number of committed writes, so 1 for the collided address.
- Different addresses written at the same edge all commit. wr_count then increments by 0..3 in one cycle, saturating.
- rd_count increments by the number of in-range reads sampled at that edge.
- Out of range (addr >= DEPTH):
  - The write is dropped.
  - The read still pipelines but returns 0 with rvalid=1.
  - oor_err sets at E0. Neither rd_count nor wr_count changes for that access.
- Address bits above clog2(DEPTH) are compared, never truncated.
- en=0: we, addr and din are ignored, with no state change.
- Clear priority:
  - stat_clr zeroes counters at the next edge and takes priority over any increment in the same cycle.
  - err_clr takes priority over a new error in the same cycle: the flag clears and the new error is lost.

Optional Feature:
- SRAM_PARITY_EN defined:
  - Each word stores an extra even-parity bit computed from din on write.
  - On read, stage 2 recomputes parity. A mismatch sets parity_err (sticky) and still returns the stored data.
  - An extra input inject_parity_err (1 bit) inverts the stored parity bit for any write committed that cycle.
- SRAM_PARITY_EN undefined:
  - No parity storage and no inject_parity_err port.
  - parity_err is constant 0.

Test Plan:
- Reset, then port1 write 0xDEADBEEF to addr 0x10. Port1 read of 0x10 in the next cycle → port1_dout=0xDEADBEEF and port1_rvalid pulses 2 cycles after the read en. wr_count=1, rd_count=1.
- Port2 reads addrs 0,1,2 on consecutive cycles after preloading 0xA0,0xA1,0xA2 → three consecutive rvalid pulses carrying 0xA0,0xA1,0xA2. dout holds 0xA2 afterwards.
- Port1, port2 and port3 write 0x11, 0x22, 0x33 to addr 5 at the same edge → mem[5]=0x11, collision_count=1, wr_count +1.
- Port3 writes 0x55 to addr 7 while port1 reads addr 7 at the same edge, with old value 0x44 → port1_dout=0x44. A subsequent port1 read returns 0x55.
- Port1 read of addr 4096 with DEPTH=4096 → dout=0, rvalid=1, oor_err=1, rd_count unchanged. err_clr → oor_err=0.
- SRAM_PARITY_EN: write 0x1 to addr 9 with inject_parity_err=1, then read addr 9 → dout=0x1, parity_err=1. Assert rst_n=0 with a read in flight → no rvalid pulse and dout=0.

Source files
------------

// File: rtl/sram_buffer_3port_if.sv
// sram_buffer_3port_if: controller-facing bundle for the 3-port SRAM buffer.
// Per-port en/we/addr/din/dout/rvalid, clears, statistics and error flags.
// SRAM_PARITY_EN adds inject_parity_err.
interface sram_buffer_3port_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 22
);
  logic                  port1_en;
  logic                  port1_we;
  logic [ADDR_WIDTH-1:0] port1_addr;
  logic [DATA_WIDTH-1:0] port1_din;
  logic [DATA_WIDTH-1:0] port1_dout;
  logic                  port1_rvalid;

  logic                  port2_en;
  logic                  port2_we;
  logic [ADDR_WIDTH-1:0] port2_addr;
  logic [DATA_WIDTH-1:0] port2_din;
  logic [DATA_WIDTH-1:0] port2_dout;
  logic                  port2_rvalid;

  logic                  port3_en;
  logic                  port3_we;
  logic [ADDR_WIDTH-1:0] port3_addr;
  logic [DATA_WIDTH-1:0] port3_din;
  logic [DATA_WIDTH-1:0] port3_dout;
  logic                  port3_rvalid;

  logic                  stat_clr;
  logic                  err_clr;
  logic [15:0]           rd_count;
  logic [15:0]           wr_count;
  logic [7:0]            collision_count;
  logic                  oor_err;
  logic                  parity_err;
`ifdef SRAM_PARITY_EN
  logic                  inject_parity_err;
`endif

  modport master (
`ifdef SRAM_PARITY_EN
    output inject_parity_err,
`endif
    output port1_en, port1_we, port1_addr, port1_din,
    output port2_en, port2_we, port2_addr, port2_din,
    output port3_en, port3_we, port3_addr, port3_din,
    output stat_clr, err_clr,
    input  port1_dout, port1_rvalid,
    input  port2_dout, port2_rvalid,
    input  port3_dout, port3_rvalid,
    input  rd_count, wr_count, collision_count,
    input  oor_err, parity_err
  );

  modport slave (
`ifdef SRAM_PARITY_EN
    input  inject_parity_err,
`endif
    input  port1_en, port1_we, port1_addr, port1_din,
    input  port2_en, port2_we, port2_addr, port2_din,
    input  port3_en, port3_we, port3_addr, port3_din,
    input  stat_clr, err_clr,
    output port1_dout, port1_rvalid,
    output port2_dout, port2_rvalid,
    output port3_dout, port3_rvalid,
    output rd_count, wr_count, collision_count,
    output oor_err, parity_err
  );
endinterface

// File: rtl/sram_buffer_3port.sv
// sram_buffer_3port: 3-port shared word buffer, 2-cycle read pipeline,
// port-order write arbitration, range check, stats. Ports: clk, rst_n, bus.
// Optional macro SRAM_PARITY_EN: per-word even parity + sticky parity_err.
module sram_buffer_3port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 22,
  parameter int DEPTH      = 4096
) (
  input logic               clk,
  input logic               rst_n,
  sram_buffer_3port_if.slave bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH+1)'(DEPTH);

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  logic [2:0] en;
  logic [2:0] we;
  addr_t      addr [3];
  word_t      din  [3];

  assign en = {bus.port3_en, bus.port2_en,
               bus.port1_en};
  assign we = {bus.port3_we, bus.port2_we,
               bus.port1_we};
  assign addr[0] = bus.port1_addr;
  assign addr[1] = bus.port2_addr;
  assign addr[2] = bus.port3_addr;
  assign din[0]  = bus.port1_din;
  assign din[1]  = bus.port2_din;
  assign din[2]  = bus.port3_din;

  logic [2:0] in_rng;
  logic [2:0] wr_req;
  logic [2:0] rd_req;
  logic [2:0] commit;
  logic       collide;
  logic       oor_hit;
  logic [1:0] n_rd;
  logic [1:0] n_wr;

  // Full-width compare: upper address bits must not alias into range.
  // A write loses to any lower port writing the same word this edge.
  always_comb begin
    in_rng  = '0;
    wr_req  = '0;
    rd_req  = '0;
    commit  = '0;
    collide = 1'b0;
    n_rd    = '0;
    n_wr    = '0;
    for (int k = 0; k < 3; k++) begin
      in_rng[k] = {1'b0, addr[k]} < LIMIT;
      wr_req[k] = en[k] & we[k] & in_rng[k];
      rd_req[k] = en[k] & ~we[k];
    end
    for (int k = 0; k < 3; k++) begin
      commit[k] = wr_req[k];
      for (int j = 0; j < k; j++) begin
        if (wr_req[j] && wr_req[k] &&
            addr[j] == addr[k]) begin
          commit[k] = 1'b0;
          collide   = 1'b1;
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_rd = n_rd + 2'(rd_req[k] & in_rng[k]);
      n_wr = n_wr + 2'(commit[k]);
    end
  end

  assign oor_hit = |(en & ~in_rng);

  word_t mem [DEPTH];
`ifdef SRAM_PARITY_EN
  logic  par_mem [DEPTH];
`endif

  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (commit[k]) begin
        mem[addr[k][IW-1:0]] <= din[k];
`ifdef SRAM_PARITY_EN
        par_mem[addr[k][IW-1:0]] <=
          (^din[k]) ^ bus.inject_parity_err;
`endif
      end
    end
  end

  logic [2:0] s1_v;
  word_t      s1_data [3];
  logic [2:0] s1_par;
  logic [2:0] rvalid_q;
  word_t      dout_q  [3];

  // Stage 1 samples the array on the same edge as writes: read-first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v     <= '0;
      s1_par   <= '0;
      rvalid_q <= '0;
      for (int k = 0; k < 3; k++) begin
        s1_data[k] <= '0;
        dout_q[k]  <= '0;
      end
    end else begin
      s1_v     <= rd_req;
      rvalid_q <= s1_v;
      for (int k = 0; k < 3; k++) begin
        if (rd_req[k]) begin
          if (in_rng[k]) begin
            s1_data[k] <= mem[addr[k][IW-1:0]];
`ifdef SRAM_PARITY_EN
            s1_par[k]  <= par_mem[addr[k][IW-1:0]];
`else
            s1_par[k]  <= 1'b0;
`endif
          end else begin
            s1_data[k] <= '0;
            s1_par[k]  <= 1'b0;
          end
        end
        if (s1_v[k]) dout_q[k] <= s1_data[k];
      end
    end
  end

  assign bus.port1_dout   = dout_q[0];
  assign bus.port2_dout   = dout_q[1];
  assign bus.port3_dout   = dout_q[2];
  assign bus.port1_rvalid = rvalid_q[0];
  assign bus.port2_rvalid = rvalid_q[1];
  assign bus.port3_rvalid = rvalid_q[2];

  function automatic logic [15:0] sat_add(
    input logic [15:0] a,
    input logic [1:0]  b
  );
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;
  logic [7:0]  col_cnt_q;
  logic        oor_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      col_cnt_q <= '0;
    end else if (bus.stat_clr) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      col_cnt_q <= '0;
    end else begin
      rd_cnt_q <= sat_add(rd_cnt_q, n_rd);
      wr_cnt_q <= sat_add(wr_cnt_q, n_wr);
      if (collide && col_cnt_q != 8'hFF)
        col_cnt_q <= col_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           oor_q <= 1'b0;
    else if (bus.err_clr) oor_q <= 1'b0;
    else if (oor_hit)     oor_q <= 1'b1;
  end

`ifdef SRAM_PARITY_EN
  logic par_q;
  logic par_bad;

  always_comb begin
    par_bad = 1'b0;
    for (int k = 0; k < 3; k++)
      if (s1_v[k] && ((^s1_data[k]) != s1_par[k]))
        par_bad = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           par_q <= 1'b0;
    else if (bus.err_clr) par_q <= 1'b0;
    else if (par_bad)     par_q <= 1'b1;
  end

  assign bus.parity_err = par_q;
`else
  logic unused_par;
  assign unused_par     = ^s1_par;
  assign bus.parity_err = 1'b0;
`endif

  assign bus.rd_count        = rd_cnt_q;
  assign bus.wr_count        = wr_cnt_q;
  assign bus.collision_count = col_cnt_q;
  assign bus.oor_err         = oor_q;
endmodule

// File: tb/tb_sram_buffer_3port.sv
// tb_sram_buffer_3port: directed table, hand sequences and random
// traffic against a behavioural model of the 3-port buffer.
module tb_sram_buffer_3port;
  localparam int DW    = 32;
  localparam int AW    = 22;
  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_buffer_3port_if #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) bus ();

  sram_buffer_3port #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  logic [2:0]    en;
  logic [2:0]    we;
  logic [AW-1:0] addr [3];
  logic [DW-1:0] din  [3];
  logic          stat_clr;
  logic          err_clr;
`ifdef SRAM_PARITY_EN
  logic          inj;
  assign bus.inject_parity_err = inj;
`endif

  assign bus.port1_en = en[0];
  assign bus.port2_en = en[1];
  assign bus.port3_en = en[2];
  assign bus.port1_we = we[0];
  assign bus.port2_we = we[1];
  assign bus.port3_we = we[2];
  assign bus.port1_addr = addr[0];
  assign bus.port2_addr = addr[1];
  assign bus.port3_addr = addr[2];
  assign bus.port1_din = din[0];
  assign bus.port2_din = din[1];
  assign bus.port3_din = din[2];
  assign bus.stat_clr = stat_clr;
  assign bus.err_clr  = err_clr;

  logic [DW-1:0] dout [3];
  logic [2:0]    rvalid;
  assign dout[0] = bus.port1_dout;
  assign dout[1] = bus.port2_dout;
  assign dout[2] = bus.port3_dout;
  assign rvalid = {bus.port3_rvalid, bus.port2_rvalid,
                   bus.port1_rvalid};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: word map, one-deep read queue per port.
  logic [DW-1:0] m_mem [int];
  bit            m_bad [int];
  bit            m_p1v   [3];
  logic [DW-1:0] m_p1d   [3];
  bit            m_p1k   [3];
  bit            m_p1bad [3];
  logic [DW-1:0] m_dout  [3];
  bit            m_known [3];
  bit [2:0]      m_rvalid;
  int            m_rd, m_wr, m_col;
  bit            m_oor, m_par;
  bit            model_on = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rvalid = '0;
      m_rd = 0; m_wr = 0; m_col = 0;
      m_oor = 0; m_par = 0;
      for (int k = 0; k < 3; k++) begin
        m_p1v[k] = 0; m_p1bad[k] = 0;
        m_dout[k] = '0; m_known[k] = 1;
      end
    end else begin
      automatic int  nrd = 0;
      automatic int  nwr = 0;
      automatic bit  col = 0;
      automatic bit  oor = 0;
      automatic bit  perr = 0;
      automatic bit  injv = 0;
      automatic int  wa [3];
      automatic int  nw = 0;
`ifdef SRAM_PARITY_EN
      injv = inj;
`endif
      for (int k = 0; k < 3; k++) begin
        m_rvalid[k] = m_p1v[k];
        if (m_p1v[k]) begin
          m_dout[k]  = m_p1d[k];
          m_known[k] = m_p1k[k];
          if (m_p1bad[k]) perr = 1;
        end
      end
      for (int k = 0; k < 3; k++) begin
        automatic int a = int'(addr[k]);
        m_p1v[k] = 0;
        m_p1bad[k] = 0;
        if (en[k]) begin
          if (a >= DEPTH) oor = 1;
          if (!we[k]) begin
            m_p1v[k] = 1;
            if (a >= DEPTH) begin
              m_p1d[k] = '0; m_p1k[k] = 1;
            end else if (m_mem.exists(a)) begin
              m_p1d[k] = m_mem[a]; m_p1k[k] = 1;
              m_p1bad[k] = m_bad[a];
              nrd++;
            end else begin
              m_p1k[k] = 0;
              nrd++;
            end
          end
        end
      end
      for (int k = 0; k < 3; k++) begin
        automatic int a = int'(addr[k]);
        automatic bit dup = 0;
        if (en[k] && we[k] && a < DEPTH) begin
          for (int j = 0; j < nw; j++)
            if (wa[j] == a) dup = 1;
          if (dup) col = 1;
          else begin
            wa[nw] = a; nw++; nwr++;
            m_mem[a] = din[k];
            m_bad[a] = injv;
          end
        end
      end
      if (stat_clr) begin
        m_rd = 0; m_wr = 0; m_col = 0;
      end else begin
        m_rd = (m_rd + nrd > 65535) ? 65535 : m_rd + nrd;
        m_wr = (m_wr + nwr > 65535) ? 65535 : m_wr + nwr;
        if (col && m_col < 255) m_col++;
      end
      if (err_clr) begin
        m_oor = 0; m_par = 0;
      end else begin
        if (oor)  m_oor = 1;
        if (perr) m_par = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on && rst_n) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("m_rvalid%0d", k + 1),
            32'(rvalid[k]), 32'(m_rvalid[k]));
        if (m_known[k])
          chk($sformatf("m_dout%0d", k + 1),
              dout[k], m_dout[k]);
      end
      chk("m_rd_count", 32'(bus.rd_count), m_rd);
      chk("m_wr_count", 32'(bus.wr_count), m_wr);
      chk("m_col_count", 32'(bus.collision_count), m_col);
      chk("m_oor_err", 32'(bus.oor_err), 32'(m_oor));
      chk("m_parity_err", 32'(bus.parity_err), 32'(m_par));
    end
  end

  task automatic idle();
    en = '0; we = '0;
    stat_clr = 0; err_clr = 0;
`ifdef SRAM_PARITY_EN
    inj = 0;
`endif
  endtask

  task automatic set_op(input int p, input bit w,
                        input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    en[p] = 1; we[p] = w; addr[p] = a; din[p] = d;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    int            p;
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp;
    bit            exp_oor;
  } vec_t;

  vec_t tbl [9];

  function automatic logic [AW-1:0] rnd_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r < 16)  return AW'(r);
    if (r == 16) return AW'(4095);
    if (r == 17) return AW'(4096);
    if (r == 18) return AW'(32'h1000 + $urandom_range(0, 15));
    return '1;
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) begin
      addr[k] = '0; din[k] = '0;
    end
    idle();
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_dout1", dout[0], 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rd_count", 32'(bus.rd_count), 0);
    chk("rst_col_count", 32'(bus.collision_count), 0);
    chk("rst_oor", 32'(bus.oor_err), 0);
    rst_n = 1;
    model_on = 1;
    @(negedge clk);

    for (int a = 0; a < 16; a++) begin
      set_op(0, 1, AW'(a), 32'hA000_0000 | a);
      step();
    end
    set_op(0, 1, AW'(4095), 32'hA000_0FFF);
    step();
    idle();
    stat_clr = 1;
    step();
    idle();

    // write then read, 2-cycle latency
    set_op(0, 1, 'h10, 32'hDEAD_BEEF);
    step();
    idle();
    set_op(0, 0, 'h10, '0);
    step();
    idle();
    chk("t1_rvalid_early", 32'(rvalid[0]), 0);
    step();
    chk("t1_rvalid", 32'(rvalid[0]), 1);
    chk("t1_dout", dout[0], 32'hDEAD_BEEF);
    chk("t1_wr_count", 32'(bus.wr_count), 1);
    chk("t1_rd_count", 32'(bus.rd_count), 1);
    step();
    chk("t1_pulse_end", 32'(rvalid[0]), 0);
    chk("t1_hold", dout[0], 32'hDEAD_BEEF);

    tbl[0] = '{0, 1, 'h20, 32'hCAFE_0001, 0, 0};
    tbl[1] = '{1, 0, 'h20, 0, 32'hCAFE_0001, 0};
    tbl[2] = '{1, 1, 4095, 32'h0FF0_0FF0, 0, 0};
    tbl[3] = '{2, 0, 4095, 0, 32'h0FF0_0FF0, 0};
    tbl[4] = '{0, 1, 4096, 32'h1234_5678, 0, 1};
    tbl[5] = '{0, 0, 0, 0, 32'hA000_0000, 0};
    tbl[6] = '{0, 0, 4096, 0, 0, 1};
    tbl[7] = '{2, 0, 'h1001, 0, 0, 1};
    tbl[8] = '{1, 0, '1, 0, 0, 1};
    for (int i = 0; i < 9; i++) begin
      idle();
      set_op(tbl[i].p, tbl[i].w, tbl[i].a, tbl[i].d);
      step();
      idle();
      step();
      chk($sformatf("tbl%0d_oor", i),
          32'(bus.oor_err), 32'(tbl[i].exp_oor));
      if (!tbl[i].w) begin
        chk($sformatf("tbl%0d_rvalid", i),
            32'(rvalid[tbl[i].p]), 1);
        chk($sformatf("tbl%0d_dout", i),
            dout[tbl[i].p], tbl[i].exp);
      end
      err_clr = 1;
      step();
      idle();
      chk($sformatf("tbl%0d_oor_clr", i),
          32'(bus.oor_err), 0);
    end

    // port2 back-to-back reads
    for (int a = 0; a < 3; a++) begin
      set_op(1, 1, AW'(a), 32'hA0 + a);
      step();
    end
    set_op(1, 0, 0, 0);
    step();
    set_op(1, 0, 1, 0);
    step();
    chk("b2b_v0", 32'(rvalid[1]), 1);
    chk("b2b_d0", dout[1], 32'hA0);
    set_op(1, 0, 2, 0);
    step();
    chk("b2b_v1", 32'(rvalid[1]), 1);
    chk("b2b_d1", dout[1], 32'hA1);
    idle();
    step();
    chk("b2b_v2", 32'(rvalid[1]), 1);
    chk("b2b_d2", dout[1], 32'hA2);
    step();
    chk("b2b_end", 32'(rvalid[1]), 0);
    chk("b2b_hold", dout[1], 32'hA2);

    // three-way collision
    stat_clr = 1;
    step();
    idle();
    set_op(0, 1, 5, 32'h11);
    set_op(1, 1, 5, 32'h22);
    set_op(2, 1, 5, 32'h33);
    step();
    idle();
    chk("col_count", 32'(bus.collision_count), 1);
    chk("col_wr_count", 32'(bus.wr_count), 1);
    set_op(2, 0, 5, 0);
    step();
    idle();
    step();
    chk("col_winner", dout[2], 32'h11);

    // read-during-write returns old data
    set_op(0, 1, 7, 32'h44);
    step();
    set_op(2, 1, 7, 32'h55);
    set_op(0, 0, 7, 0);
    step();
    idle();
    set_op(0, 0, 7, 0);
    step();
    idle();
    chk("rdw_old", dout[0], 32'h44);
    step();
    chk("rdw_new", dout[0], 32'h55);

    // clear priorities
    set_op(0, 0, 4096, 0);
    err_clr = 1;
    step();
    idle();
    chk("errclr_prio", 32'(bus.oor_err), 0);
    set_op(1, 1, 3, 32'h77);
    stat_clr = 1;
    step();
    idle();
    chk("statclr_prio", 32'(bus.wr_count), 0);

    // collision counter saturation
    for (int i = 0; i < 260; i++) begin
      set_op(0, 1, 3, 32'(i));
      set_op(1, 1, 3, 32'hFFFF);
      step();
    end
    idle();
    chk("col_sat", 32'(bus.collision_count), 255);
    chk("col_sat_wr", 32'(bus.wr_count), 260);

`ifdef SRAM_PARITY_EN
    set_op(0, 1, 9, 32'h1);
    inj = 1;
    step();
    idle();
    set_op(0, 0, 9, 0);
    step();
    idle();
    step();
    chk("par_dout", dout[0], 32'h1);
    chk("par_err", 32'(bus.parity_err), 1);
    err_clr = 1;
    step();
    idle();
    chk("par_clr", 32'(bus.parity_err), 0);
`endif

    // reset with a read in flight
    set_op(0, 0, 'h10, 0);
    step();
    idle();
    rst_n = 0;
    step();
    chk("midrst_rvalid", 32'(rvalid[0]), 0);
    chk("midrst_dout", dout[0], 0);
    rst_n = 1;
    step();
    chk("midrst_after", 32'(rvalid[0]), 0);

    for (int i = 0; i < 2000; i++) begin
      idle();
      for (int k = 0; k < 3; k++) begin
        en[k]   = ($urandom_range(0, 1) == 1);
        we[k]   = ($urandom_range(0, 1) == 1);
        addr[k] = rnd_addr();
        din[k]  = $urandom;
      end
      stat_clr = ($urandom_range(0, 49) == 0);
      err_clr  = ($urandom_range(0, 19) == 0);
`ifdef SRAM_PARITY_EN
      inj = ($urandom_range(0, 9) == 0);
`endif
      step();
    end
    idle();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
